// File: rtl/mem_copy_engine_pkg.sv
// Shared definitions for the memory copy engine.
//   - state_e     : copy engine FSM states
//   - ADDR_W      : byte address width of the attached memory
//   - MEM_BYTES   : size of the attached memory in bytes
//   - word_bytes  : bytes per W-bit word
//   - range_ok    : true when a block of nbytes starting at addr fits in memory
package mem_copy_engine_pkg;

  localparam int ADDR_W    = 8;
  localparam int MEM_BYTES = 256;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    FIN   = 3'd3,
    ERR   = 3'd4
  } state_e;

  function automatic int word_bytes(input int w);
    return w / 8;
  endfunction

  // End address is computed 17 bits wide so a block running off the top of
  // memory can never wrap back into range.
  function automatic logic range_ok(input logic [ADDR_W-1:0] addr,
                                    input logic [15:0]       nbytes);
    logic [16:0] end_excl;
    end_excl = {9'd0, addr} + {1'b0, nbytes};
    return (end_excl <= 17'(MEM_BYTES));
  endfunction

endpackage

// File: rtl/mem_copy_engine.sv
// Memory copy engine: bus master that copies len W-bit words from src_addr to
// dst_addr in ascending address order, one READ cycle and one WRITE cycle per
// word, driving a byte-addressed memory with asynchronous read data.
//
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   start             : copy request, sampled only in IDLE
//   src_addr/dst_addr : byte address of first source / destination word
//   len               : number of words to copy
//   busy              : high in READ and WRITE
//   done / err        : one-cycle pulses on completion / rejected request
//   mem_address       : memory byte address
//   mem_wrt_enable    : memory write strobe
//   mem_wrt_data      : memory write data
//   mem_read_data     : memory asynchronous read data
//
// Handshake: start is a level request; it is acted on only at an edge where
// the engine is in IDLE. Requests seen in any other state are dropped.
//
// All outputs are flops loaded with the decode of the next state, so during a
// cycle they are a pure function of the current state. A reset edge that
// lands during WRITE therefore still lets the memory capture that word.
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter int W  = 8,
  parameter int LW = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LW-1:0]     len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_wrt_enable,
  output logic [W-1:0]      mem_wrt_data,
  input  logic [W-1:0]      mem_read_data
);

  localparam int BYTES = word_bytes(W);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic [W-1:0]      data_q, data_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [W-1:0]      wdata_q, wdata_d;

  logic [15:0]       len_bytes;
  logic              req_ok;

  assign len_bytes = 16'(len) * 16'(BYTES);
  assign req_ok    = range_ok(src_addr, len_bytes) && range_ok(dst_addr, len_bytes);

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    data_d  = data_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (!req_ok) begin
            state_d = ERR;
          end else if (len == '0) begin
            state_d = FIN;
          end else begin
            src_d   = src_addr;
            dst_d   = dst_addr;
            cnt_d   = len;
            state_d = READ;
          end
        end
      end
      READ: begin
        data_d  = mem_read_data;
        state_d = WRITE;
      end
      WRITE: begin
        src_d   = src_q + ADDR_W'(BYTES);
        dst_d   = dst_q + ADDR_W'(BYTES);
        cnt_d   = cnt_q - LW'(1);
        state_d = (cnt_q == LW'(1)) ? FIN : READ;
      end
      FIN:     state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Output decode of the next state; addresses use the updated pointers.
    busy_d  = (state_d == READ) || (state_d == WRITE);
    done_d  = (state_d == FIN);
    err_d   = (state_d == ERR);
    we_d    = (state_d == WRITE);
    addr_d  = '0;
    wdata_d = '0;
    if (state_d == READ) begin
      addr_d = src_d;
    end else if (state_d == WRITE) begin
      addr_d  = dst_d;
      wdata_d = data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign mem_wrt_enable = we_q;
  assign mem_address    = addr_q;
  assign mem_wrt_data   = wdata_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: a W=8 and a W=16 instance, each attached to its
// own byte-addressed memory model with asynchronous little-endian reads.
module tb_mem_copy_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // W=8 instance signals
  logic       start8 = 1'b0;
  logic [7:0] src8 = '0, dst8 = '0;
  logic [8:0] len8 = '0;
  logic       busy8, done8, err8, we8;
  logic [7:0] addr8, wdata8, rd8;

  // W=16 instance signals
  logic        start16 = 1'b0;
  logic [7:0]  src16 = '0, dst16 = '0;
  logic [8:0]  len16 = '0;
  logic        busy16, done16, err16, we16;
  logic [7:0]  addr16, addr16_p1;
  logic [15:0] wdata16, rd16;

  mem_copy_engine #(.W(8), .LW(9)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .src_addr(src8), .dst_addr(dst8),
    .len(len8), .busy(busy8), .done(done8), .err(err8), .mem_address(addr8),
    .mem_wrt_enable(we8), .mem_wrt_data(wdata8), .mem_read_data(rd8)
  );

  mem_copy_engine #(.W(16), .LW(9)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .src_addr(src16), .dst_addr(dst16),
    .len(len16), .busy(busy16), .done(done16), .err(err16), .mem_address(addr16),
    .mem_wrt_enable(we16), .mem_wrt_data(wdata16), .mem_read_data(rd16)
  );

  // ---------------- memory models ----------------
  logic [7:0] mem8  [256];
  logic [7:0] mem16 [256];
  logic [7:0] snap8 [256];
  logic       clr = 1'b0;
  logic       pl_en = 1'b0;
  logic       pl_sel = 1'b0;
  logic [7:0] pl_addr = '0, pl_data = '0;

  assign rd8       = mem8[addr8];
  assign addr16_p1 = addr16 + 8'd1;
  assign rd16      = {mem16[addr16_p1], mem16[addr16]};

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem8[i] <= 8'h00;
    end else if (pl_en && !pl_sel) begin
      mem8[pl_addr] <= pl_data;
    end else if (we8) begin
      mem8[addr8] <= wdata8;
    end
  end

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem16[i] <= 8'h00;
    end else if (pl_en && pl_sel) begin
      mem16[pl_addr] <= pl_data;
    end else if (we16) begin
      mem16[addr16]    <= wdata16[7:0];
      mem16[addr16_p1] <= wdata16[15:8];
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic poke(input logic sel, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_sel  = sel;
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // Issues one request, then watches 24 cycles after the accepting edge.
  // Cycle k is sampled on the falling edge inside the k-th cycle after E0.
  task automatic run_copy(input logic sel, input logic [7:0] s, input logic [7:0] d,
                          input logic [8:0] l, output int busy_n, output int done_at,
                          output int done_n, output int err_at, output int err_n,
                          output int we_n);
    logic b, dn, e, w;
    busy_n = 0; done_at = 0; done_n = 0; err_at = 0; err_n = 0; we_n = 0;
    @(negedge clk);
    if (!sel) begin
      src8 = s; dst8 = d; len8 = l; start8 = 1'b1;
    end else begin
      src16 = s; dst16 = d; len16 = l; start16 = 1'b1;
    end
    @(posedge clk);
    #1 start8 = 1'b0;
    start16 = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      b  = sel ? busy16 : busy8;
      dn = sel ? done16 : done8;
      e  = sel ? err16  : err8;
      w  = sel ? we16   : we8;
      if (b) busy_n++;
      if (w) we_n++;
      if (dn) begin
        done_n++;
        if (done_at == 0) done_at = k;
      end
      if (e) begin
        err_n++;
        if (err_at == 0) err_at = k;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  int busy_n, done_at, done_n, err_at, err_n, we_n, diffs, k_done;

  initial begin
    // Reset and memory clear
    clr = 1'b1;
    repeat (3) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", busy8, 0);
    check_eq("rst_done_err", {done8, err8}, 0);
    check_eq("rst_we", we8, 0);
    check_eq("rst_addr", addr8, 0);
    check_eq("rst_wdata", wdata8, 0);
    check_eq("rst_w16_outs", {busy16, done16, err16, we16, addr16, wdata16}, 0);
    rst_n = 1'b1;

    // Preload
    poke(0, 8'h10, 8'hA0); poke(0, 8'h11, 8'hA1);
    poke(0, 8'h12, 8'hA2); poke(0, 8'h13, 8'hA3);
    poke(0, 8'hFD, 8'hD1); poke(0, 8'hFE, 8'hD2); poke(0, 8'hFF, 8'hD3);
    poke(0, 8'h60, 8'h66);
    poke(0, 8'h00, 8'h01); poke(0, 8'h01, 8'h02);
    poke(0, 8'h02, 8'h03); poke(0, 8'h03, 8'h04);
    poke(0, 8'hC0, 8'h5A); poke(0, 8'hC1, 8'h5A);
    poke(0, 8'hC2, 8'h5A); poke(0, 8'hC3, 8'h5A);
    poke(1, 8'h20, 8'h11); poke(1, 8'h21, 8'h22);
    poke(1, 8'h22, 8'h33); poke(1, 8'h23, 8'h44);
    poke(1, 8'h40, 8'h77); poke(1, 8'h45, 8'h88);

    // Basic 4-word copy, W=8
    run_copy(0, 8'h10, 8'h80, 9'd4, busy_n, done_at, done_n, err_at, err_n, we_n);
    check_eq("basic_busy_cycles", busy_n, 8);
    check_eq("basic_done_cycle", done_at, 9);
    check_eq("basic_done_count", done_n, 1);
    check_eq("basic_err_count", err_n, 0);
    check_eq("basic_we_count", we_n, 4);
    check_eq("basic_mem", {mem8[8'h80], mem8[8'h81], mem8[8'h82], mem8[8'h83]}, 32'hA0A1A2A3);

    // Unaligned 2-word copy, W=16
    run_copy(1, 8'h20, 8'h41, 9'd2, busy_n, done_at, done_n, err_at, err_n, we_n);
    check_eq("w16_done_cycle", done_at, 5);
    check_eq("w16_busy_cycles", busy_n, 4);
    check_eq("w16_mem", {mem16[8'h41], mem16[8'h42], mem16[8'h43], mem16[8'h44]}, 32'h11223344);
    check_eq("w16_edges_kept", {mem16[8'h40], mem16[8'h45]}, 16'h7788);

    // Range error on source
    for (int i = 0; i < 256; i++) snap8[i] = mem8[i];
    run_copy(0, 8'hFE, 8'h60, 9'd3, busy_n, done_at, done_n, err_at, err_n, we_n);
    check_eq("err_src_cycle", err_at, 1);
    check_eq("err_src_count", err_n, 1);
    check_eq("err_src_no_we", we_n, 0);
    check_eq("err_src_no_busy_done", busy_n + done_n, 0);
    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem8[i] !== snap8[i]) diffs++;
    check_eq("err_src_mem_unchanged", diffs, 0);

    // Range error on destination
    run_copy(0, 8'h00, 8'hFF, 9'd2, busy_n, done_at, done_n, err_at, err_n, we_n);
    check_eq("err_dst_cycle", err_at, 1);
    check_eq("err_dst_no_we", we_n, 0);

    // Exactly-fitting block at top of memory
    run_copy(0, 8'hFD, 8'h60, 9'd3, busy_n, done_at, done_n, err_at, err_n, we_n);
    check_eq("fit_err_count", err_n, 0);
    check_eq("fit_done_cycle", done_at, 7);
    check_eq("fit_mem", {mem8[8'h60], mem8[8'h61], mem8[8'h62]}, 24'hD1D2D3);

    // Zero-length request
    run_copy(0, 8'h10, 8'h80, 9'd0, busy_n, done_at, done_n, err_at, err_n, we_n);
    check_eq("len0_done_cycle", done_at, 1);
    check_eq("len0_busy", busy_n, 0);
    check_eq("len0_we", we_n, 0);
    check_eq("len0_err", err_n, 0);

    // Overlapping ascending copy, then back-to-back request
    @(negedge clk);
    src8 = 8'h00; dst8 = 8'h01; len8 = 9'd3; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    k_done = 0;
    for (int k = 1; k <= 20 && k_done == 0; k++) begin
      @(negedge clk);
      if (done8) k_done = k;
    end
    check_eq("ovl_done_cycle", k_done, 7);
    @(posedge clk);
    #1 src8 = 8'h00; dst8 = 8'h90; len8 = 9'd2; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    @(negedge clk);
    check_eq("b2b_accepted_busy", busy8, 1);
    k_done = 0;
    for (int k = 2; k <= 20 && k_done == 0; k++) begin
      @(negedge clk);
      if (done8) k_done = k;
    end
    check_eq("b2b_done_cycle", k_done, 5);
    check_eq("ovl_mem", {mem8[8'h00], mem8[8'h01], mem8[8'h02], mem8[8'h03]}, 32'h01010101);
    check_eq("b2b_mem", {mem8[8'h90], mem8[8'h91]}, 16'h0101);

    // Reset during the second WRITE of a 4-word copy
    @(negedge clk);
    src8 = 8'h10; dst8 = 8'hC0; len8 = 9'd4; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("midrst_in_write", {we8, addr8}, {1'b1, 8'hC1});
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("midrst_outs_zero", {busy8, done8, err8, we8, addr8, wdata8}, 0);
    done_n = 0; we_n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done8) done_n++;
      if (we8) we_n++;
    end
    check_eq("midrst_no_done", done_n, 0);
    check_eq("midrst_no_more_we", we_n, 0);
    check_eq("midrst_mem", {mem8[8'hC0], mem8[8'hC1], mem8[8'hC2], mem8[8'hC3]}, 32'hA0A15A5A);

    run_copy(0, 8'h12, 8'hC2, 9'd2, busy_n, done_at, done_n, err_at, err_n, we_n);
    check_eq("after_rst_done_cycle", done_at, 5);
    check_eq("after_rst_mem", {mem8[8'hC0], mem8[8'hC1], mem8[8'hC2], mem8[8'hC3]}, 32'hA0A1A2A3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
